// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-clock valid/error pulses.
// States: IDLE wait start | START_CHK confirm start | DATA shift 8 bits | STOP_BIT check stop | BREAK_WAIT wait line high
module uart_rx #(
    parameter int Fclk  = 50000000,
    parameter int Fuart = 2400
) (
    input  logic       clk_Rx,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       receive_flg
);

    localparam int divider = Fclk / Fuart;
    localparam logic [24:0] CNT_BIT = 25'(divider - 1);
    localparam logic [24:0] CNT_MID = 25'(divider / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP_BIT,
        BREAK_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_s;
    logic [24:0] cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        sample_data;
    logic        stop_done;

    always_ff @(posedge clk_Rx or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_Rx or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sample_data = (state == DATA) && (cnt == CNT_BIT);
        stop_done   = (state == STOP_BIT) && (cnt == CNT_BIT);
        case (state)
            IDLE:       if (!rx_s) state_nxt = START_CHK;
            START_CHK:  if (cnt == CNT_MID) state_nxt = rx_s ? IDLE : DATA;
            DATA:       if (sample_data && bit_cnt == 4'd7) state_nxt = STOP_BIT;
            // Leaving mid stop bit keeps back-to-back start edges visible
            STOP_BIT:   if (stop_done) state_nxt = rx_s ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rx_s) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_Rx or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state_nxt != state || state == IDLE || state == BREAK_WAIT || sample_data)
                cnt <= '0;
            else
                cnt <= cnt + 25'd1;

            if (state == IDLE)
                bit_cnt <= '0;
            else if (sample_data)
                bit_cnt <= bit_cnt + 4'd1;

            if (sample_data)
                shift_reg <= {rx_s, shift_reg[7:1]};

            if (stop_done) begin
                if (rx_s) begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

    assign receive_flg = (state == START_CHK) || (state == DATA) || (state == STOP_BIT);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at divider 16: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_uart_rx;
    localparam int DIV = 16;

    logic       clk_Rx = 1'b0;
    logic       reset  = 1'b1;
    logic       Rx_in  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       receive_flg;

    uart_rx #(.Fclk(160), .Fuart(10)) dut (
        .clk_Rx      (clk_Rx),
        .reset       (reset),
        .Rx_in       (Rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .receive_flg (receive_flg)
    );

    always #5 clk_Rx = ~clk_Rx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int valid_seen = 0;
    int ferr_seen = 0;
    logic [7:0] exp_q[$];
    int vt[$];
    logic [7:0] c3 = 8'hC3;

    always @(posedge clk_Rx) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_Rx);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        Rx_in = 1'b0;
        t0 = cyc;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            Rx_in = b[i];
            tick(DIV);
        end
        Rx_in = stop_bit;
        tick(DIV);
        Rx_in = 1'b1;
    endtask

    always @(negedge clk_Rx) begin
        if (frame_err) ferr_seen++;
        if (data_valid) begin
            valid_seen++;
            vt.push_back(cyc);
            check("valid_ferr_exclusive", frame_err, 0);
            check("flg_low_at_valid", receive_flg, 0);
            if (exp_q.size() == 0) check("unexpected_valid_queue", exp_q.size(), 1);
            else check("data_out", data_out, exp_q.pop_front());
        end
    end

    initial begin
        tick(3);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_flg", receive_flg, 0);
        reset = 1'b0;
        tick(5);

        // single frame
        vt.delete();
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("single_count", valid_seen, 1);
        if (vt.size() == 1) check_near("single_latency", vt[0] - t0, 2 + 9 * DIV + DIV / 2, 2);
        check("single_ferr", ferr_seen, 0);
        check("single_flg_idle", receive_flg, 0);

        // back-to-back
        vt.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);
        check("b2b_count", valid_seen, 4);
        check("b2b_pulses", vt.size(), 3);
        if (vt.size() == 3) begin
            check_near("b2b_spacing1", vt[1] - vt[0], 10 * DIV, 2);
            check_near("b2b_spacing2", vt[2] - vt[1], 10 * DIV, 2);
        end

        // glitch
        Rx_in = 1'b0;
        tick(5);
        check("glitch_flg_high", receive_flg, 1);
        Rx_in = 1'b1;
        tick(30);
        check("glitch_flg_low", receive_flg, 0);
        check("glitch_no_valid", valid_seen, 4);
        check("glitch_no_ferr", ferr_seen, 0);
        send_frame(8'h81, 1'b1);
        tick(20);
        check("after_glitch_count", valid_seen, 5);

        // framing error
        send_frame(8'h5A, 1'b0);
        tick(30);
        check("ferr_count", ferr_seen, 1);
        check("ferr_no_valid", valid_seen, 5);
        check("ferr_data_kept", data_out, 8'h81);
        send_frame(8'h12, 1'b1);
        tick(20);
        check("after_ferr_count", valid_seen, 6);

        // break
        Rx_in = 1'b0;
        tick(400);
        check("break_flg_low", receive_flg, 0);
        Rx_in = 1'b1;
        tick(30);
        check("break_ferr_count", ferr_seen, 2);
        check("break_no_valid", valid_seen, 6);
        check("break_data_kept", data_out, 8'h12);

        // reset during data bit 4 of 0xC3
        Rx_in = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            Rx_in = c3[i];
            tick(DIV);
        end
        Rx_in = c3[4];
        tick(8);
        check("midframe_flg_before", receive_flg, 1);
        reset = 1'b1;
        #1;
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_valid", data_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_flg", receive_flg, 0);
        tick(3);
        Rx_in = 1'b1;
        reset = 1'b0;
        tick(20);
        send_frame(8'h7E, 1'b1);
        tick(20);
        check("final_valid_count", valid_seen, 7);
        check("final_ferr_count", ferr_seen, 2);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_data_out", data_out, 8'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
